uart_txrx_top: RTL and testbench
================================

Name: uart_txrx_top

Overview:
- Full-duplex 8-bit UART: one transmitter and one receiver sharing a clock, baud rate and parity configuration.
- Frame format: 1 start bit (0), 8 data bits LSB first, an optional parity bit, then 1 stop bit (1).
- Sits between a byte-level host interface and the serial pins; rx_ext may be tied to tx_ext for loopback.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208 at defaults): clock cycles per serial bit. Derived; not overridden directly.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous active-low reset.
- tx_start  in  1  transmit request; sampled only while the transmitter is IDLE.
- tx_data  in  8  byte to send; latched when tx_start is accepted.
- par_en  in  1  1 = parity bit present in the frame.
- par_ty  in  1  parity type: 0 = even, 1 = odd.
- rx_ext  in  1  serial input line; idles high.
- tx_ext  out  1  serial output line; idles high.
- rx_data  out  8  last received byte.
- rx_done  out  1  one-cycle pulse when a frame completes.
- parity_error  out  1  parity mismatch on the last frame.
- framing_error  out  1  stop bit of the last frame was sampled low.
- tx_busy  out  1  high while a frame is being transmitted.

Behaviour:
- Reset (rst=0, asynchronous): both FSMs go to IDLE and all counters clear. tx_ext=1, tx_busy=0, rx_data=0, rx_done=0, parity_error=0, framing_error=0.
- Reset asserted mid-frame aborts the frame immediately. tx_ext returns to 1 and no rx_done pulse is produced.
- State encoding, used by both FSMs: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- Each FSM register is named state and lives in sub-instances tx_i and rx_i. The bench probes these hierarchy paths.
- TX path, IDLE: if tx_start=1, latch tx_data, par_en and par_ty, move to START and set tx_busy=1 on the next edge. tx_start while busy is ignored.
- TX START: drive 0 for CLKS_PER_BIT cycles.
- TX DATA: drive bits 0..7, each for CLKS_PER_BIT cycles.
- TX PARITY: entered only if par_en is latched as 1. Drives ^data for even parity, ~^data for odd parity.
- TX STOP: drive 1 for CLKS_PER_BIT cycles, then return to IDLE with tx_busy=0.
- TX next frame: may start on the cycle after tx_busy falls.
- RX path: rx_ext passes through a 2-FF synchronizer before any use.
- RX IDLE: a high-to-low transition on the synchronized line moves to START and latches par_en and par_ty.
- RX START: re-sample at CLKS_PER_BIT/2. If the line is still low, go to DATA; if high, treat as a glitch and return to IDLE with no outputs changed.
- RX DATA: sample at each bit centre (every CLKS_PER_BIT cycles) into a shift register, LSB first.
- RX PARITY: if par_en is latched, sample the parity bit at its centre.
- RX STOP: sample at the stop-bit centre. In that same cycle:
  - rx_data <= shifted byte;
  - framing_error <= (stop bit == 0);
  - parity_error <= par_en & (received parity != expected parity), else 0;
  - rx_done = 1 for exactly one cycle;
  - FSM returns to IDLE.
- Error flags and rx_data hold their values until the next completed frame. rx_done pulses even when a frame has errors.
- TX and RX run independently, so full duplex is allowed. Changing par_en or par_ty mid-frame has no effect on the frame in progress.

Decomposition:
- Package uart_pkg holds:
  - the state typedef/constants (IDLE..STOP);
  - a parity function (data, type) -> bit.
- Sub-module uart_tx (instance tx_i): contains its own baud counter.
- Sub-module uart_rx (instance rx_i): contains its own baud counter.
- The top level only wires the two sub-modules; no other logic.

Test Plan:
- Loopback (rx_ext=tx_ext), par_en=1, par_ty=0, send 0xAF:
  - tx_ext sequence 0,1,1,1,1,0,1,0,1,0(parity),1.
  - tx_busy high for 11×5208 cycles.
  - rx_done pulse with rx_data=0xAF, parity_error=0, framing_error=0.
- Send 0x3C, then 0xBB, each launched after rx_done of the previous byte: rx_data=0x3C then 0xBB, both error flags 0 each time.
- par_ty=1, send 0xAF: parity bit=1, rx_data=0xAF, parity_error=0.
- par_en=0, send 0x55: tx_busy lasts 10 bit times, no parity bit, rx_data=0x55.
- Drive rx_ext externally:
  - 0xA5 frame with a wrong parity bit -> parity_error=1.
  - 0xA5 frame with stop bit 0 -> framing_error=1.
  - rx_done pulses in both cases.
  - A 100-cycle low glitch on rx_ext -> no rx_done.
- Assert rst mid-transmission of 0xFF:
  - tx_ext=1, tx_busy=0 and both states=0 immediately.
  - A following send of 0x12 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: the FSM state
// encoding used by both directions and the parity helper.
package uart_pkg;

    // Both FSMs use the same encoding so debug probes read the same way.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Parity bit for a byte: ty=0 even (xor of data), ty=1 odd (xnor of data).
    function automatic logic parity_bit(input logic [7:0] data, input logic ty);
        return ty ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_if.sv
// Byte-level host interface of the UART.
//
// Handshake: tx_start acts as valid and ~tx_busy as ready. A byte on tx_data
// is accepted on a rising edge where tx_start=1 and tx_busy=0; tx_busy rises
// on that same edge and falls when the stop bit ends. Requests made while
// tx_busy=1 are dropped, not queued. rx_done is a one-cycle strobe with no
// back-pressure; rx_data and the error flags hold until the next frame.
interface uart_if;
    import uart_pkg::*;

    logic        tx_start;
    logic [7:0]  tx_data;
    logic        par_en;
    logic        par_ty;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        parity_error;
    logic        framing_error;
    uart_state_t tx_state;
    uart_state_t rx_state;

    modport master (
        output tx_start, tx_data, par_en, par_ty,
        input  tx_busy, rx_data, rx_done, parity_error, framing_error,
        input  tx_state, rx_state
    );

    modport slave (
        input  tx_start, tx_data, par_en, par_ty,
        output tx_busy, rx_data, rx_done, parity_error, framing_error,
        output tx_state, rx_state
    );

endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the line, detects the start edge, confirms the
// start bit at its centre, then samples every bit at its centre.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_ext,
    input  logic        par_en,
    input  logic        par_ty,
    output logic [7:0]  rx_data,
    output logic        rx_done,
    output logic        parity_error,
    output logic        framing_error,
    output uart_state_t dbg_state
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_par;
    logic          par_en_q, par_ty_q;
    logic          bit_end;

    assign bit_end   = (cnt == LAST);
    assign dbg_state = state;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_ext;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receive FSM; results and flags update only when the stop bit is sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            rx_par        <= 1'b0;
            par_en_q      <= 1'b0;
            par_ty_q      <= 1'b0;
            rx_data       <= '0;
            rx_done       <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_s2) begin
                        par_en_q <= par_en;
                        par_ty_q <= par_ty;
                        state    <= START;
                    end
                end
                START: begin
                    // A line back high at mid-start is a glitch, not a frame.
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s2 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        shift   <= {rx_s2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= par_en_q ? PARITY : STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt    <= '0;
                        rx_par <= rx_s2;
                        state  <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt           <= '0;
                        rx_data       <= shift;
                        framing_error <= !rx_s2;
                        parity_error  <= par_en_q && (rx_par != parity_bit(shift, par_ty_q));
                        rx_done       <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop.
// The frame configuration is latched at acceptance so mid-frame changes on
// par_en/par_ty cannot corrupt the frame in flight.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [7:0]  tx_data,
    input  logic        par_en,
    input  logic        par_ty,
    output logic        tx_ext,
    output logic        tx_busy,
    output uart_state_t dbg_state
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_q;
    logic          par_en_q;
    logic          bit_end;

    assign bit_end   = (cnt == LAST);
    assign dbg_state = state;

    // Transmit FSM; tx_ext is registered and changes on bit boundaries only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            tx_ext   <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (tx_start) begin
                        shift    <= tx_data;
                        par_en_q <= par_en;
                        par_q    <= parity_bit(tx_data, par_ty);
                        tx_ext   <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx_ext  <= shift[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            if (par_en_q) begin
                                tx_ext <= par_q;
                                state  <= PARITY;
                            end else begin
                                tx_ext <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            tx_ext <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt    <= '0;
                        tx_ext <= 1'b1;
                        state  <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt     <= '0;
                    tx_ext  <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_txrx_top.sv
// Full-duplex UART top: wires the independent transmitter and receiver to the
// host interface and the serial pins. Both halves share one baud setting.
module uart_txrx_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    uart_if.slave host,
    input  logic rx_ext,
    output logic tx_ext
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) tx_i (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (host.tx_start),
        .tx_data   (host.tx_data),
        .par_en    (host.par_en),
        .par_ty    (host.par_ty),
        .tx_ext    (tx_ext),
        .tx_busy   (host.tx_busy),
        .dbg_state (host.tx_state)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) rx_i (
        .clk           (clk),
        .rst           (rst),
        .rx_ext        (rx_ext),
        .par_en        (host.par_en),
        .par_ty        (host.par_ty),
        .rx_data       (host.rx_data),
        .rx_done       (host.rx_done),
        .parity_error  (host.parity_error),
        .framing_error (host.framing_error),
        .dbg_state     (host.rx_state)
    );

endmodule

// File: tb/tb_uart_txrx_top.sv
// Bench for uart_txrx_top: loopback and externally driven frames, with a
// scoreboard of expected {parity_error, framing_error, rx_data} words.
module tb_uart_txrx_top;
    import uart_pkg::*;

    localparam int CLK_FREQ = 25_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic clk;
    logic rst;
    logic loopback;
    logic ext_drv;
    logic rx_line;
    logic tx_ext;

    logic [9:0] exp_q[$];
    int n_checks;
    int n_fail;
    int rx_cnt;

    uart_if u_if ();

    assign rx_line = loopback ? tx_ext : ext_drv;

    uart_txrx_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk    (clk),
        .rst    (rst),
        .host   (u_if.slave),
        .rx_ext (rx_line),
        .tx_ext (tx_ext)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every rx_done pops one expected word
    always @(negedge clk) begin
        if (u_if.rx_done) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                check("rx_unexpected", 32'd1, 32'd0);
            end else begin
                check("rx_word", {22'd0, u_if.parity_error, u_if.framing_error, u_if.rx_data},
                      {22'd0, exp_q.pop_front()});
            end
        end
    end

    // Loopback send; checks every bit at its centre and the busy length.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt);
        logic [10:0] bits;
        int nb;
        int cyc;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pe) bits[9] = pt ? ~^d : ^d;
        nb = pe ? 11 : 10;
        exp_q.push_back({2'b00, d});
        @(negedge clk);
        u_if.tx_start = 1'b1;
        u_if.tx_data  = d;
        u_if.par_en   = pe;
        u_if.par_ty   = pt;
        @(posedge clk);
        #1;
        u_if.tx_start = 1'b0;
        cyc = 0;
        while (u_if.tx_busy && cyc < 12 * CPB) begin
            if ((cyc % CPB) == CPB / 2 && (cyc / CPB) < nb)
                check("tx_bit", {31'd0, tx_ext}, {31'd0, bits[cyc / CPB]});
            @(posedge clk);
            #1;
            cyc++;
        end
        check("tx_busy_len", cyc, nb * CPB);
    endtask

    // External frame on rx_ext with optional corrupted parity or stop bit.
    task automatic drive_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic bad_par, input logic bad_stop);
        logic [10:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pe) bits[9] = (pt ? ~^d : ^d) ^ bad_par;
        nb = pe ? 11 : 10;
        bits[nb - 1] = ~bad_stop;
        exp_q.push_back({bad_par & pe, bad_stop, d});
        loopback = 1'b0;
        u_if.par_en = pe;
        u_if.par_ty = pt;
        @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            ext_drv = bits[i];
            repeat (CPB) @(negedge clk);
        end
        ext_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic wait_rx(input int target);
        int n;
        n = 0;
        while (rx_cnt < target && n < 20 * CPB) begin
            @(posedge clk);
            n++;
        end
        check("rx_done_count", rx_cnt, target);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rx_cnt   = 0;
        rst      = 1'b0;
        loopback = 1'b1;
        ext_drv  = 1'b1;
        u_if.tx_start = 1'b0;
        u_if.tx_data  = 8'h00;
        u_if.par_en   = 1'b1;
        u_if.par_ty   = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("rst_tx_ext", {31'd0, tx_ext}, 32'd1);
        check("rst_tx_busy", {31'd0, u_if.tx_busy}, 32'd0);
        check("rst_rx_word", {22'd0, u_if.parity_error, u_if.framing_error, u_if.rx_data}, 32'd0);
        check("rst_rx_done", {31'd0, u_if.rx_done}, 32'd0);
        check("rst_tx_state", 32'(dut.tx_i.state), 32'd0);
        check("rst_rx_state", 32'(dut.rx_i.state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // loopback, even parity, then back-to-back bytes
        send_frame(8'hAF, 1'b1, 1'b0);
        wait_rx(1);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_rx(2);
        send_frame(8'hBB, 1'b1, 1'b0);
        wait_rx(3);
        // odd parity: parity bit for 0xAF becomes 1
        send_frame(8'hAF, 1'b1, 1'b1);
        wait_rx(4);
        // no parity: ten bit times
        send_frame(8'h55, 1'b0, 1'b0);
        wait_rx(5);

        // externally driven error frames
        drive_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_rx(6);
        drive_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_rx(7);

        // short low glitch must not start a frame; flags keep last values
        @(negedge clk);
        ext_drv = 1'b0;
        repeat (100) @(negedge clk);
        ext_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_no_rx_done", rx_cnt, 7);
        check("glitch_rx_state", 32'(dut.rx_i.state), 32'd0);
        check("flags_hold", {22'd0, u_if.parity_error, u_if.framing_error, u_if.rx_data},
              {22'd0, 2'b01, 8'hA5});

        // reset in the middle of a loopback frame
        loopback = 1'b1;
        @(negedge clk);
        u_if.tx_start = 1'b1;
        u_if.tx_data  = 8'hFF;
        u_if.par_en   = 1'b1;
        u_if.par_ty   = 1'b0;
        @(negedge clk);
        u_if.tx_start = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        check("midframe_busy", {31'd0, u_if.tx_busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_tx_ext", {31'd0, tx_ext}, 32'd1);
        check("abort_tx_busy", {31'd0, u_if.tx_busy}, 32'd0);
        check("abort_tx_state", 32'(dut.tx_i.state), 32'd0);
        check("abort_rx_state", 32'(dut.rx_i.state), 32'd0);
        check("abort_rx_word", {22'd0, u_if.parity_error, u_if.framing_error, u_if.rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("abort_no_rx_done", rx_cnt, 7);

        send_frame(8'h12, 1'b1, 1'b0);
        wait_rx(8);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
